// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle: operation request on one side,
// registered result and {F, L, C, N, Z} flags on the other.
interface alu_multicycle_if #(
    parameter int WIDTH = 16
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic [3:0]       op_i;
    logic [WIDTH-1:0] A_i;
    logic [WIDTH-1:0] B_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic [WIDTH-1:0] alu_o;
    logic [4:0]       flags_o;

    modport master (
        output req_valid_i, op_i, A_i, B_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, alu_o, flags_o
    );

    modport slave (
        input  req_valid_i, op_i, A_i, B_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, alu_o, flags_o
    );
endinterface

// File: rtl/alu_multicycle.sv
// Registered ALU with single-cycle arithmetic/logic, bit-serial shifts and a
// shift-add multiplier; one operation in flight, result held until consumed.
module alu_multicycle #(
    parameter int WIDTH = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    alu_multicycle_if.slave    bus
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_CMP = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SAR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;

    typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_t;

    state_t               state, state_next;
    logic [3:0]           op_q;
    logic [WIDTH-1:0]     a_q;
    logic [WIDTH-1:0]     sh_q;
    logic [2*WIDTH-1:0]   prod_q;
    logic [SHW-1:0]       cnt_q;
    logic [WIDTH-1:0]     alu_q;
    logic [4:0]           flags_q;

    logic                 accept;
    logic [3:0]           op_cur;
    logic [SHW-1:0]       shamt;
    logic [WIDTH-1:0]     sh_src, sh_step, mcand;
    logic                 sh_out;
    logic [2*WIDTH-1:0]   prod_src, prod_step;
    logic [WIDTH:0]       mul_sum, add_sum, sub_diff;
    logic                 load;
    logic                 legal;
    logic [WIDTH-1:0]     res;
    logic                 c_flag, f_flag, l_flag;
    logic [4:0]           flags_next;

    assign accept = bus.req_valid_i && (state == IDLE);
    assign shamt  = bus.B_i[SHW-1:0];

    // The accept edge already performs the first shift / multiply iteration,
    // so step logic reads the live inputs in IDLE and the working regs after.
    always_comb begin
        op_cur   = (state == IDLE) ? bus.op_i : op_q;
        sh_src   = (state == IDLE) ? bus.A_i : sh_q;
        mcand    = (state == IDLE) ? bus.A_i : a_q;
        prod_src = (state == IDLE) ? {{WIDTH{1'b0}}, bus.B_i} : prod_q;

        sh_step = {sh_src[WIDTH-1], sh_src[WIDTH-1:1]};
        sh_out  = sh_src[0];
        if (op_cur == OP_SHL) begin
            sh_step = {sh_src[WIDTH-2:0], 1'b0};
            sh_out  = sh_src[WIDTH-1];
        end else if (op_cur == OP_SHR) begin
            sh_step = {1'b0, sh_src[WIDTH-1:1]};
        end

        mul_sum   = {1'b0, prod_src[2*WIDTH-1:WIDTH]}
                  + (prod_src[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        prod_step = {mul_sum, prod_src[WIDTH-1:1]};

        add_sum  = {1'b0, bus.A_i} + {1'b0, bus.B_i};
        sub_diff = {1'b0, bus.A_i} + {1'b0, ~bus.B_i} + {{WIDTH{1'b0}}, 1'b1};
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        legal      = 1'b1;
        res        = '0;
        c_flag     = 1'b0;
        f_flag     = 1'b0;
        l_flag     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid_i) begin
                    load       = 1'b1;
                    state_next = DONE;
                    case (bus.op_i)
                        OP_ADD: begin
                            res    = add_sum[WIDTH-1:0];
                            c_flag = add_sum[WIDTH];
                            f_flag = (bus.A_i[WIDTH-1] == bus.B_i[WIDTH-1]) &&
                                     (add_sum[WIDTH-1] != bus.A_i[WIDTH-1]);
                        end
                        OP_SUB, OP_CMP: begin
                            res    = sub_diff[WIDTH-1:0];
                            c_flag = ~sub_diff[WIDTH];
                            l_flag = ~sub_diff[WIDTH];
                            f_flag = (bus.A_i[WIDTH-1] != bus.B_i[WIDTH-1]) &&
                                     (sub_diff[WIDTH-1] != bus.A_i[WIDTH-1]);
                        end
                        OP_AND: res = bus.A_i & bus.B_i;
                        OP_OR:  res = bus.A_i | bus.B_i;
                        OP_XOR: res = bus.A_i ^ bus.B_i;
                        OP_SHL, OP_SHR, OP_SAR: begin
                            if (shamt == '0) begin
                                res = bus.A_i;
                            end else if (shamt == SHW'(1)) begin
                                res    = sh_step;
                                c_flag = sh_out;
                            end else begin
                                load       = 1'b0;
                                state_next = SHIFT;
                            end
                        end
                        OP_MUL: begin
                            load       = 1'b0;
                            state_next = MUL;
                        end
                        default: legal = 1'b0;
                    endcase
                end
            end
            SHIFT: begin
                if (cnt_q == SHW'(1)) begin
                    load       = 1'b1;
                    res        = sh_step;
                    c_flag     = sh_out;
                    state_next = DONE;
                end
            end
            MUL: begin
                if (cnt_q == SHW'(1)) begin
                    load       = 1'b1;
                    res        = prod_step[WIDTH-1:0];
                    c_flag     = |prod_step[2*WIDTH-1:WIDTH];
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        flags_next = legal ? {f_flag, l_flag, c_flag, res[WIDTH-1], res == '0} : 5'b0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q    <= '0;
            a_q     <= '0;
            sh_q    <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            alu_q   <= '0;
            flags_q <= '0;
        end else begin
            if (accept) begin
                op_q   <= bus.op_i;
                a_q    <= bus.A_i;
                sh_q   <= sh_step;
                prod_q <= prod_step;
                cnt_q  <= (bus.op_i == OP_MUL) ? SHW'(WIDTH - 1) : shamt - SHW'(1);
            end else if (state == SHIFT) begin
                sh_q  <= sh_step;
                cnt_q <= cnt_q - SHW'(1);
            end else if (state == MUL) begin
                prod_q <= prod_step;
                cnt_q  <= cnt_q - SHW'(1);
            end
            if (load) begin
                alu_q   <= res;
                flags_q <= flags_next;
            end
        end
    end

    assign bus.req_ready_o = (state == IDLE);
    assign bus.rsp_valid_o = (state == DONE);
    assign bus.alu_o       = alu_q;
    assign bus.flags_o     = flags_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Directed-vector bench for alu_multicycle: table of hand-computed results plus
// sequences for reset, backpressure and queued requests.
module tb_alu_multicycle;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    alu_multicycle_if #(.WIDTH(16)) bus ();

    alu_multicycle #(.WIDTH(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] exp_alu;
        logic [4:0]  exp_flags;
        int          exp_lat;
    } vec_t;

    vec_t vecs [18];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one request, scrambles the operands after accept, waits (bounded)
    // for the response, then acknowledges it.
    task automatic apply_stimulus(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                  output int lat, output logic [15:0] res, output logic [4:0] flg);
        int guard = 0;
        while (!bus.req_ready_o && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        bus.req_valid_i = 1'b1;
        bus.op_i        = op;
        bus.A_i         = a;
        bus.B_i         = b;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        bus.A_i         = ~a;
        bus.B_i         = b ^ 16'h5A5A;
        bus.op_i        = op ^ 4'h1;
        lat = 1;
        while (!bus.rsp_valid_o && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus.alu_o;
        flg = bus.flags_o;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
    endtask

    initial begin
        int          lat;
        logic [15:0] res;
        logic [4:0]  flg;
        logic        seen;

        vecs[0]  = '{4'd0,  16'hFFFF, 16'h0001, 16'h0000, 5'b00101, 1};
        vecs[1]  = '{4'd1,  16'h8000, 16'h0001, 16'h7FFF, 5'b10000, 1};
        vecs[2]  = '{4'd2,  16'h0003, 16'h0005, 16'hFFFE, 5'b01110, 1};
        vecs[3]  = '{4'd0,  16'h7FFF, 16'h0001, 16'h8000, 5'b10010, 1};
        vecs[4]  = '{4'd3,  16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00000, 1};
        vecs[5]  = '{4'd4,  16'h1200, 16'h0034, 16'h1234, 5'b00000, 1};
        vecs[6]  = '{4'd5,  16'h00FF, 16'h0F0F, 16'h0FF0, 5'b00000, 1};
        vecs[7]  = '{4'd6,  16'h8001, 16'h0013, 16'h0008, 5'b00000, 3};
        vecs[8]  = '{4'd8,  16'h8000, 16'h0004, 16'hF800, 5'b00010, 4};
        vecs[9]  = '{4'd6,  16'h1234, 16'h0000, 16'h1234, 5'b00000, 1};
        vecs[10] = '{4'd7,  16'h0003, 16'h0001, 16'h0001, 5'b00100, 1};
        vecs[11] = '{4'd7,  16'h8000, 16'h000F, 16'h0001, 5'b00000, 15};
        vecs[12] = '{4'd9,  16'h0100, 16'h0100, 16'h0000, 5'b00101, 16};
        vecs[13] = '{4'd9,  16'h00FF, 16'h0003, 16'h02FD, 5'b00000, 16};
        vecs[14] = '{4'd9,  16'hFFFF, 16'hFFFF, 16'h0001, 5'b00100, 16};
        vecs[15] = '{4'd12, 16'h0005, 16'h0005, 16'h0000, 5'b00000, 1};
        vecs[16] = '{4'd1,  16'h0005, 16'h0005, 16'h0000, 5'b00001, 1};
        vecs[17] = '{4'd8,  16'h8001, 16'h0001, 16'hC000, 5'b00110, 1};

        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b0;
        bus.op_i        = 4'd0;
        bus.A_i         = 16'h0000;
        bus.B_i         = 16'h0000;

        repeat (2) @(posedge clk);
        #1;
        check_output("reset_alu", 32'(bus.alu_o), 32'h0);
        check_output("reset_flags", 32'(bus.flags_o), 32'h0);
        check_output("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
        #2 rst = 1'b0;
        #1 check_output("reset_req_ready", 32'(bus.req_ready_o), 32'h1);
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, lat, res, flg);
            check_output($sformatf("vec%0d_alu", i), 32'(res), 32'(vecs[i].exp_alu));
            check_output($sformatf("vec%0d_flags", i), 32'(flg), 32'(vecs[i].exp_flags));
            check_output($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
        end

        // Backpressure with a second request queued on the inputs.
        bus.req_valid_i = 1'b1;
        bus.op_i        = 4'd5;
        bus.A_i         = 16'h00FF;
        bus.B_i         = 16'h0F0F;
        @(posedge clk); #1;
        bus.op_i = 4'd0;
        bus.A_i  = 16'h0001;
        bus.B_i  = 16'h0002;
        for (int k = 0; k < 5; k++) begin
            check_output($sformatf("stall%0d_alu", k), 32'(bus.alu_o), 32'h0FF0);
            check_output($sformatf("stall%0d_req_ready", k), 32'(bus.req_ready_o), 32'h0);
            check_output($sformatf("stall%0d_rsp_valid", k), 32'(bus.rsp_valid_o), 32'h1);
            @(posedge clk); #1;
        end
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;
        check_output("handshake_req_ready", 32'(bus.req_ready_o), 32'h1);
        check_output("handshake_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        check_output("queued_rsp_valid", 32'(bus.rsp_valid_o), 32'h1);
        check_output("queued_alu", 32'(bus.alu_o), 32'h0003);
        check_output("queued_flags", 32'(bus.flags_o), 32'h0);
        bus.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready_i = 1'b0;

        // Asynchronous reset mid-cycle while a result is held in DONE.
        bus.req_valid_i = 1'b1;
        bus.op_i        = 4'd0;
        bus.A_i         = 16'h1234;
        bus.B_i         = 16'h1111;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        check_output("held_alu", 32'(bus.alu_o), 32'h2345);
        #2 rst = 1'b1;
        #1;
        check_output("async_reset_alu", 32'(bus.alu_o), 32'h0);
        check_output("async_reset_rsp_valid", 32'(bus.rsp_valid_o), 32'h0);
        #1 rst = 1'b0;
        check_output("async_reset_req_ready", 32'(bus.req_ready_o), 32'h1);
        @(posedge clk); #1;

        // Reset pulsed at cycle 8 of a multiply discards it.
        seen = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.op_i        = 4'd9;
        bus.A_i         = 16'h0100;
        bus.B_i         = 16'h0100;
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
        repeat (7) begin
            @(posedge clk); #1;
            seen |= bus.rsp_valid_o;
        end
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        check_output("mul_reset_flags", 32'(bus.flags_o), 32'h0);
        repeat (20) begin
            @(posedge clk); #1;
            seen |= bus.rsp_valid_o;
        end
        check_output("mul_reset_no_rsp", 32'(seen), 32'h0);
        check_output("mul_reset_req_ready", 32'(bus.req_ready_o), 32'h1);
        apply_stimulus(4'd0, 16'h0002, 16'h0003, lat, res, flg);
        check_output("post_reset_add_alu", 32'(res), 32'h0005);
        check_output("post_reset_add_flags", 32'(flg), 32'h0);
        check_output("post_reset_add_latency", lat, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_multicycle.md
# alu_multicycle

Parametrised, registered successor to the combinational 16-bit ALU. It adds multi-cycle shift and multiply operations, valid/ready handshakes on the request and response sides, and registered F/L/C/N/Z flags. It sits between the decode/operand-read stage and writeback. It accepts one operation at a time and holds its result until writeback consumes it.

## Interface
- WIDTH, 16, datapath width; must be a power of two and ≥ 4
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

- clk_i  input  1  clock; all state changes on the rising edge
- rst_i  input  1  reset, asynchronous, active-high
- req_valid_i  input  1  request present
- req_ready_o  output  1  block can accept a request
- op_i  input  4  operation code (see Operation)
- A_i  input  WIDTH  operand A
- B_i  input  WIDTH  operand B; for shifts, only B_i[SHW-1:0] is used
- rsp_valid_o  output  1  result and flags are valid
- rsp_ready_i  input  1  consumer takes the response
- alu_o  output  WIDTH  registered result
- flags_o  output  5  registered flags: {F, L, C, N, Z}

## Operation
- States: IDLE, SHIFT, MUL, DONE.
- req_ready_o = (state == IDLE). rsp_valid_o = (state == DONE).
- **Accept:** a request is accepted when req_valid_i && req_ready_o at a rising edge. op_i, A_i and B_i are captured into internal registers. Later changes on these inputs are ignored.
- **Op codes:**
  - 0 ADD: A+B.
  - 1 SUB: A+~B+1.
  - 2 CMP: same computation as SUB.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 SHL: logical left shift.
  - 7 SHR: logical right shift.
  - 8 SAR: arithmetic right shift.
  - 9 MUL: unsigned multiply; alu_o carries the low WIDTH bits.
  - 10–15: illegal; alu_o = 0 and flags = 0.
- **Single-cycle ops (0–5, illegal):** IDLE → DONE at the accept edge.
- **Shifts (6–8):**
  - If shamt = 0: IDLE → DONE, result = A, C = 0.
  - Otherwise: IDLE → SHIFT with count = shamt. Each SHIFT cycle shifts by one bit and decrements count. The edge that performs the last shift moves to DONE.
- **MUL:** IDLE → MUL. Shift-add over WIDTH iterations, one per cycle, into a 2·WIDTH product register. The last iteration edge moves to DONE.
- **DONE:** alu_o and flags_o are held stable. DONE → IDLE at the edge where rsp_ready_i = 1. No request is accepted in the same cycle.
- **Flags:** all flags are updated only on the transition into DONE.
  - Z = (alu_o == 0).
  - N = alu_o[WIDTH-1].
  - ADD:
    - C = carry out.
    - F = signed overflow.
    - L = 0.
  - SUB/CMP:
    - C = borrow (A < B unsigned).
    - L = (A < B unsigned).
    - F = signed overflow of A−B.
  - Logic ops: C = F = L = 0.
  - Shifts:
    - C = last bit shifted out.
    - F = L = 0.
  - MUL:
    - C = (high WIDTH bits ≠ 0).
    - F = L = 0.
- **Width rule:** all adder arithmetic is WIDTH+1 bits wide, with the carry taken from the top bit.
- **Reset:** rst_i asserted in any state, including mid-SHIFT or mid-MUL:
  - Goes to IDLE immediately and discards the operation.
  - alu_o = 0, flags_o = 0, rsp_valid_o = 0.
  - req_ready_o = 1 after rst_i deasserts.

## Timing
- **Latency** is counted from the accept edge to the edge after which rsp_valid_o is high:
  - ops 0–5 and illegal: 1 cycle.
  - shifts: max(1, shamt) cycles.
  - MUL: WIDTH cycles.
- **Throughput:** at most one request per (latency + 1) cycles when rsp_ready_i is held high.
- **Backpressure:** while rsp_ready_i = 0 in DONE:
  - req_ready_o stays 0.
  - Outputs do not change.
  - There is no limit on stall length.
- **Busy behaviour:** req_valid_i held during SHIFT, MUL or DONE is neither accepted nor lost. It is accepted on the first cycle the block is back in IDLE.
- **Stability:** alu_o and flags_o change only on the entry into DONE and on reset.

## Test plan
- **Reset:** assert rst_i asynchronously, mid-cycle.
  - Required: all outputs read 0 and req_ready_o = 1 after release.
  - Then, with WIDTH=16, ADD 0xFFFF + 0x0001 → alu_o = 0x0000, flags_o = 5'b00101, rsp_valid_o high exactly 1 cycle after accept.
- **SUB:** 0x8000 − 0x0001 → alu_o = 0x7FFF, flags_o = 5'b10000.
- **CMP:** A = 0x0003, B = 0x0005 → alu_o = 0xFFFE, flags_o = 5'b01110.
- **Shifts:**
  - SHL A = 0x8001, B = 0x0013 (shamt 3) → alu_o = 0x0008, C = 0, latency 3.
  - SAR A = 0x8000, B = 0x0004 → alu_o = 0xF800.
  - SHL with shamt 0 → alu_o = A, latency 1.
- **MUL:** 0x0100 × 0x0100 → alu_o = 0x0000, flags_o = 5'b00101, latency 16.
  - Repeat the same operation with rst_i pulsed at cycle 8: the response is never asserted, and a following ADD completes correctly.
- **Backpressure:** hold rsp_ready_i = 0 for 5 cycles after an XOR of 0x00FF ^ 0x0F0F.
  - Required: alu_o = 0x0FF0 stable throughout, and req_ready_o = 0 throughout.
  - A queued request that was held on the inputs is accepted 1 cycle after the handshake.
  - Changing A_i/B_i mid-operation does not alter the result.
